uart_tx_word: RTL and testbench
===============================

Name: uart_tx_word

Overview:
Serial transmitter matching the rs_rx receive path. It accepts 32-bit result words from the core on a send_enable/send_data strobe and buffers them in a small FIFO. Each word goes out on rs_tx as a sequence of 8N1 UART frames. It sits between the core's send port and the board TX pin, so the host sees results such as the Fibonacci output stream.

Parameters:
CLKS_PER_BIT, 5, clock cycles per serial bit; legal range is 2 or more; the default matches the simulation bit time of 50 units at a 10-unit clock.
WORD_BYTES, 4, bytes sent per word; legal range 1..4; only the low WORD_BYTES bytes of send_data are sent.
FIFO_AW, 2, FIFO address width; depth is 2**FIFO_AW words (default 4).

Ports:
clk  in  1  system clock; all state updates on the rising edge.
xreset  in  1  asynchronous active-low reset.
send_data  in  32  word to transmit; sampled when send_enable is 1.
send_enable  in  1  single-cycle write strobe; one word per cycle it is high.
rs_tx  out  1  serial line; idles high.
full  out  1  FIFO holds 2**FIFO_AW words.
busy  out  1  high while a frame is in progress or the FIFO is non-empty.
overflow  out  1  sticky; set when a write is dropped; cleared only by reset.

Behaviour:
- Reset (xreset=0, asynchronous): rs_tx=1, full=0, busy=0, overflow=0. FIFO is emptied, FSM goes to IDLE, all counters are 0. A reset in mid-frame aborts the frame and the line returns high immediately.
- Write acceptance: a word is pushed when send_enable=1 and (full=0 or a pop happens in the same cycle).
  - Otherwise the word is dropped and overflow is set to 1 on that edge.
  - A simultaneous push and pop leaves the count unchanged.
- FIFO: pointers wrap modulo the depth; count has FIFO_AW+1 bits; full = (count == depth).
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: rs_tx=1. If the FIFO is non-empty, pop the head word into the word register, set byte index = WORD_BYTES-1, and go to START.
  - START: rs_tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: rs_tx = the current byte's bit[bit index], LSB first. Each bit lasts CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: rs_tx=1 for CLKS_PER_BIT cycles. Then:
    - byte index > 0: decrement the index and go to START.
    - byte index = 0 and FIFO non-empty: pop the next word and go to START, with no idle cycle.
    - otherwise: go to IDLE.
- Byte order: most significant transmitted byte first, i.e. byte WORD_BYTES-1 (bits [8*WORD_BYTES-1 : 8*WORD_BYTES-8]) down to byte 0 (bits [7:0]).
- Latency: a word written at edge N into an empty FIFO while IDLE is popped at edge N+1, and rs_tx falls after edge N+1.
- Frame time: 10*CLKS_PER_BIT cycles per byte; word time is WORD_BYTES*10*CLKS_PER_BIT cycles. Back-to-back frames have no gaps.
- Output timing: rs_tx is driven from a register (glitch-free); busy = (state != IDLE) or (count != 0).
- Bit timer counts 0..CLKS_PER_BIT-1 and reloads at each bit boundary.

Test Plan:
- Single word, defaults: send 0x00000050 once. Required on rs_tx:
  - bytes 0x00, 0x00, 0x00, 0x50, each with start bit 0 and stop bit 1;
  - the 0x50 frame bit sequence is 0,0,0,0,0,1,0,1,0,1, with 5 clocks per bit;
  - busy is high for 200 cycles starting the edge after the write, then rs_tx=1 and busy=0.
- Back-to-back stream: write 1, 2, 3, 5 on consecutive cycles, then 8 after the FIFO drains by one. Required:
  - a receiver model decodes 1, 2, 3, 5, 8 in order;
  - there is no idle-high gap between frames (total 1000 cycles);
  - overflow stays 0.
- Overflow: write 6 words on 6 consecutive cycles (0x11..0x16). Required:
  - full=1 after the 5th write (one word popped, four held);
  - the 6th word is dropped and overflow=1;
  - the line sends 0x11..0x15 only;
  - overflow stays 1 after the FIFO drains.
- Push while full with a simultaneous pop: hold the FIFO full and issue a write on the exact cycle the FSM pops at the STOP-to-START word boundary. Required: the write is accepted, overflow stays 0, and full stays 1.
- Reset mid-frame: pull xreset low at the 3rd DATA bit of the first byte of 0xA5A5A5A5. Required:
  - rs_tx=1 with no clock edge needed, busy=0, full=0;
  - after release the line stays idle;
  - a new write of 0x00000089 transmits cleanly and decodes to 0x89 as the last byte.
- Parameter variant WORD_BYTES=1, CLKS_PER_BIT=16: write 0x12345634. Required: one 160-cycle frame carrying 0x34 only.

Source files
------------

// File: rtl/uart_tx_word.sv
// Word-oriented 8N1 UART transmitter: a small FIFO of 32-bit words, each sent
// as WORD_BYTES back-to-back frames, most significant byte first.
module uart_tx_word #(
    parameter int CLKS_PER_BIT = 5,
    parameter int WORD_BYTES   = 4,
    parameter int FIFO_AW      = 2
) (
    input  logic        clk,
    input  logic        xreset,
    input  logic [31:0] send_data,
    input  logic        send_enable,
    output logic        rs_tx,
    output logic        full,
    output logic        busy,
    output logic        overflow
);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int TW    = $clog2(CLKS_PER_BIT);

    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [1:0]    BYTE_LAST = 2'(WORD_BYTES - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [31:0]        mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count;
    logic [1:0]         state;
    logic [TW-1:0]      bit_cnt;
    logic [2:0]         bit_idx;
    logic [1:0]         byte_idx;
    logic [31:0]        word;
    logic [7:0]         cur_byte;
    logic               bit_end, fifo_ne, pop, push;

    assign fifo_ne  = (count != '0);
    assign bit_end  = (bit_cnt == BIT_LAST);
    // The next word is fetched either from idle or straight out of the last stop bit,
    // so a queued word never leaves an idle gap on the line.
    assign pop      = fifo_ne && ((state == S_IDLE) ||
                                  (state == S_STOP && bit_end && byte_idx == 2'd0));
    assign push     = send_enable && (!full || pop);
    assign full     = (count == (FIFO_AW+1)'(DEPTH));
    assign busy     = (state != S_IDLE) || fifo_ne;
    assign cur_byte = word[{byte_idx, 3'b000} +: 8];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= send_data;
    end

    always_ff @(posedge clk or negedge xreset) begin
        if (!xreset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (send_enable && !push) overflow <= 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge xreset) begin
        if (!xreset) begin
            state    <= S_IDLE;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            word     <= '0;
            rs_tx    <= 1'b1;
        end else begin
            bit_cnt <= bit_end ? '0 : bit_cnt + 1'b1;
            case (state)
                S_IDLE: begin
                    bit_cnt <= '0;
                    if (pop) begin
                        word     <= mem[rd_ptr];
                        byte_idx <= BYTE_LAST;
                        state    <= S_START;
                        rs_tx    <= 1'b0;
                    end
                end
                S_START: if (bit_end) begin
                    state   <= S_DATA;
                    bit_idx <= '0;
                    rs_tx   <= cur_byte[0];
                end
                S_DATA: if (bit_end) begin
                    if (bit_idx == 3'd7) begin
                        state <= S_STOP;
                        rs_tx <= 1'b1;
                    end else begin
                        bit_idx <= bit_idx + 3'd1;
                        rs_tx   <= cur_byte[bit_idx + 3'd1];
                    end
                end
                S_STOP: if (bit_end) begin
                    if (byte_idx != 2'd0) begin
                        byte_idx <= byte_idx - 2'd1;
                        state    <= S_START;
                        rs_tx    <= 1'b0;
                    end else if (pop) begin
                        word     <= mem[rd_ptr];
                        byte_idx <= BYTE_LAST;
                        state    <= S_START;
                        rs_tx    <= 1'b0;
                    end else begin
                        state <= S_IDLE;
                        rs_tx <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_word.sv
// Bench for uart_tx_word: a timing-level model predicts every line cycle and the
// byte stream; a UART receiver decodes the line and pops expected bytes.
module tb_uart_tx_word;
    logic        clk = 1'b0;
    logic        xreset;
    logic [1:0]  en, tx, bsy, ful, ovf;
    logic [31:0] dat [2];

    int ntests = 0, nfail = 0, cyc = 0;
    int cpb [2] = '{5, 16};
    int wb  [2] = '{4, 1};

    // model state: FIFO contents, occupancy, when the current word started and ends
    logic [31:0] mf [2][4];
    int          mrd [2], mwr [2], mcnt [2], free_at [2], pop_edge [2];
    logic [31:0] cur_w [2];
    bit          movf [2];
    logic [7:0]  sbq0 [$], sbq1 [$];
    int          rx_k [2] = '{-1, -1};
    logic [7:0]  rx_b [2];

    always #5 clk = ~clk;

    uart_tx_word dut0 (.clk(clk), .xreset(xreset), .send_data(dat[0]), .send_enable(en[0]),
                       .rs_tx(tx[0]), .full(ful[0]), .busy(bsy[0]), .overflow(ovf[0]));
    uart_tx_word #(.CLKS_PER_BIT(16), .WORD_BYTES(1), .FIFO_AW(2)) dut1 (
                       .clk(clk), .xreset(xreset), .send_data(dat[1]), .send_enable(en[1]),
                       .rs_tx(tx[1]), .full(ful[1]), .busy(bsy[1]), .overflow(ovf[1]));

    task automatic check(string name, int d, logic [31:0] act, logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s dut%0d cycle %0d: got %0h, expected %0h", name, d, cyc, act, exp);
        end
    endtask

    // Line level after the current edge: start bit, 8 data bits LSB first, stop bit.
    function automatic logic exp_tx(int d);
        int k, byt, pos;
        if (cyc >= free_at[d]) return 1'b1;
        k   = cyc - pop_edge[d];
        byt = wb[d] - 1 - k / (10 * cpb[d]);
        pos = (k % (10 * cpb[d])) / cpb[d];
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return cur_w[d][byt*8 + pos - 1];
    endfunction

    task automatic model_step(int d);
        bit do_pop, do_push;
        do_pop  = (mcnt[d] > 0) && (cyc >= free_at[d]);
        do_push = en[d] && ((mcnt[d] < 4) || do_pop);
        if (do_pop) begin
            cur_w[d]    = mf[d][mrd[d]];
            mrd[d]      = (mrd[d] + 1) % 4;
            pop_edge[d] = cyc;
            free_at[d]  = cyc + wb[d] * 10 * cpb[d];
        end
        if (do_push) begin
            mf[d][mwr[d]] = dat[d];
            mwr[d] = (mwr[d] + 1) % 4;
            for (int j = wb[d] - 1; j >= 0; j--)
                if (d == 0) sbq0.push_back(dat[d][8*j +: 8]);
                else        sbq1.push_back(dat[d][8*j +: 8]);
        end else if (en[d]) movf[d] = 1'b1;
        mcnt[d] = mcnt[d] + int'(do_push) - int'(do_pop);
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int d = 0; d < 2; d++) begin
            if (!xreset) begin
                mcnt[d] = 0; mrd[d] = 0; mwr[d] = 0; free_at[d] = 0; pop_edge[d] = 0;
                movf[d] = 1'b0;
                if (d == 0) sbq0.delete(); else sbq1.delete();
            end else model_step(d);
        end
    end

    // Monitor: per-cycle flag/line checks plus a receiver that pops the scoreboard.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!xreset) begin
                check("rst_rs_tx", d, tx[d], 1);
                check("rst_busy", d, bsy[d], 0);
                rx_k[d] = -1;
            end else begin
                check("full", d, ful[d], mcnt[d] == 4);
                check("overflow", d, ovf[d], movf[d]);
                check("busy", d, bsy[d], (mcnt[d] > 0) || (cyc < free_at[d]));
                check("rs_tx", d, tx[d], exp_tx(d));
                if (rx_k[d] < 0) begin
                    if (tx[d] == 1'b0) rx_k[d] = 0;
                end else rx_k[d] = rx_k[d] + 1;
                if (rx_k[d] >= 0 && (rx_k[d] % cpb[d]) == cpb[d] / 2) begin
                    int b;
                    b = rx_k[d] / cpb[d];
                    if (b == 0) check("rx_start", d, tx[d], 0);
                    else if (b <= 8) rx_b[d][b-1] = tx[d];
                    else begin
                        logic [7:0] e;
                        check("rx_stop", d, tx[d], 1);
                        if ((d == 0 ? sbq0.size() : sbq1.size()) == 0) begin
                            ntests++; nfail++;
                            $display("FAIL rx_unexpected dut%0d cycle %0d: got byte %0h, expected none", d, cyc, rx_b[d]);
                        end else begin
                            e = (d == 0) ? sbq0.pop_front() : sbq1.pop_front();
                            check("rx_byte", d, rx_b[d], e);
                        end
                        rx_k[d] = -1;
                    end
                end
            end
        end
    end

    task automatic drive(int d, logic [31:0] w, logic e);
        #1; dat[d] = w; en[d] = e;
    endtask

    task automatic drain(int d);
        int i;
        for (i = 0; i < 5000 && (mcnt[d] != 0 || cyc < free_at[d]); i++) @(negedge clk);
        check("drain_timeout", d, i < 5000, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk); #2 xreset = 1'b0;
        @(negedge clk); @(negedge clk); #2 xreset = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int tgt, wn;
        xreset = 1'b0; en = '0; dat[0] = '0; dat[1] = '0;
        repeat (3) @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check("reset_rs_tx", d, tx[d], 1);
            check("reset_full", d, ful[d], 0);
            check("reset_busy", d, bsy[d], 0);
            check("reset_overflow", d, ovf[d], 0);
        end
        #1 xreset = 1'b1;
        repeat (4) @(negedge clk);

        // single word
        @(negedge clk); drive(0, 32'h0000_0050, 1'b1);
        @(negedge clk); drive(0, 32'h0, 1'b0);
        drain(0);

        // back-to-back stream, fifth word once one slot frees
        foreach (dat[i]) ;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); drive(0, (i == 3) ? 32'd5 : 32'(i + 1), 1'b1);
        end
        @(negedge clk); drive(0, 32'h0, 1'b0);
        for (int i = 0; i < 1000 && mcnt[0] >= 3; i++) @(negedge clk);
        drive(0, 32'd8, 1'b1);
        @(negedge clk); drive(0, 32'h0, 1'b0);
        drain(0);
        check("b2b_no_overflow", 0, ovf[0], 0);

        // overflow: sixth consecutive write is dropped
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 5) check("ovf_full_after_5th", 0, ful[0], 1);
            drive(0, 32'h11 + i, 1'b1);
        end
        @(negedge clk);
        check("ovf_set", 0, ovf[0], 1);
        check("ovf_full_held", 0, ful[0], 1);
        drive(0, 32'h0, 1'b0);
        drain(0);
        check("ovf_sticky", 0, ovf[0], 1);
        pulse_reset();
        @(negedge clk);
        check("ovf_cleared", 0, ovf[0], 0);

        // push while full, landing on the word-boundary pop
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); drive(0, 32'hC0 + i, 1'b1);
        end
        @(negedge clk); drive(0, 32'h0, 1'b0);
        check("simul_prefull", 0, ful[0], 1);
        tgt = free_at[0] - 1;
        for (int i = 0; i < 1000 && cyc < tgt; i++) @(negedge clk);
        check("simul_align", 0, cyc, tgt);
        drive(0, 32'hCF, 1'b1);
        @(negedge clk);
        check("simul_full", 0, ful[0], 1);
        check("simul_ovf", 0, ovf[0], 0);
        drive(0, 32'h0, 1'b0);
        drain(0);

        // reset during the third data bit of the first byte
        @(negedge clk); drive(0, 32'hA5A5_A5A5, 1'b1);
        wn = cyc + 1;
        @(negedge clk); drive(0, 32'h0, 1'b0);
        for (int i = 0; i < 1000 && cyc < wn + 1 + 16; i++) @(negedge clk);
        check("midrst_align", 0, cyc, wn + 17);
        #2 xreset = 1'b0;
        #1;
        check("midrst_rs_tx", 0, tx[0], 1);
        check("midrst_busy", 0, bsy[0], 0);
        check("midrst_full", 0, ful[0], 0);
        @(negedge clk); @(negedge clk); #2 xreset = 1'b1;
        repeat (50) @(negedge clk);
        check("midrst_idle", 0, tx[0], 1);
        @(negedge clk); drive(0, 32'h0000_0089, 1'b1);
        @(negedge clk); drive(0, 32'h0, 1'b0);
        drain(0);

        // narrow variant: one 16-clock-per-bit frame
        @(negedge clk); drive(1, 32'h1234_5634, 1'b1);
        @(negedge clk); drive(1, 32'h0, 1'b0);
        drain(1);

        check("sb_empty", 0, sbq0.size(), 0);
        check("sb_empty", 1, sbq1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
